// File: rtl/fetch_unit_if.sv
// Bundles the icache request/response and the decode-stage handshake/redirect
// signals seen by the instruction fetch unit.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] npc;
    logic        dec_ready;
    logic [1:0]  PCSrc;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] j_addr26;
    logic [31:0] jr_addr;
    logic        halt;
    logic [31:0] fetch_count;

    modport master (
        input  ihit, iload, dec_ready, PCSrc, branch_taken, imm16, j_addr26, jr_addr, halt,
        output imemREN, imemaddr, instr, instr_valid, npc, fetch_count
    );

    modport slave (
        output ihit, iload, dec_ready, PCSrc, branch_taken, imm16, j_addr26, jr_addr, halt,
        input  imemREN, imemaddr, instr, instr_valid, npc, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests words from the icache, hands them to
// decode and follows the decoded redirect to form the next PC.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        next_pc    = pc_plus4;
        unique case (bus.PCSrc)
            2'd0: next_pc = pc_plus4;
            2'd1: next_pc = bus.branch_taken ? (pc_plus4 + branch_off) : pc_plus4;
            2'd2: next_pc = {pc_plus4[31:28], bus.j_addr26, 2'b00};
            2'd3: next_pc = {bus.jr_addr[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Halt still commits the redirect target; it only stops the next fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            FETCH: begin
                if (bus.ihit) begin
                    instr_d = bus.iload;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.dec_ready) begin
                    pc_d = next_pc;
                    if (fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                    state_d = bus.halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= FETCH;
            pc_q          <= PC_INIT;
            instr_q       <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Outputs depend on registered state only, so no input reaches them in the same cycle.
    assign bus.imemREN     = (state_q == FETCH);
    assign bus.imemaddr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.npc         = pc_plus4;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic clk;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Model: "waiting" = a request is outstanding, "holding" = a word awaits
    // decode, "stopped" = halt was delivered.
    bit          m_waiting, m_holding, m_stopped;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    longint      m_delivered;

    function automatic logic [31:0] refTarget(input logic [31:0] pc, input logic [1:0] src,
                                              input logic tk, input logic [15:0] imm,
                                              input logic [25:0] j, input logic [31:0] jr);
        longint seq;
        longint off;
        seq = (longint'(pc) + 4) % 64'h1_0000_0000;
        off = longint'($signed(imm)) * 4;
        case (src)
            2'd1:    return tk ? 32'((seq + off) & 64'hFFFF_FFFF) : 32'(seq);
            2'd2:    return (32'(seq) & 32'hF000_0000) | (32'(j) * 32'd4);
            2'd3:    return jr - (jr % 32'd4);
            default: return 32'(seq);
        endcase
    endfunction

    task automatic modelReset();
        m_waiting   = 1'b1;
        m_holding   = 1'b0;
        m_stopped   = 1'b0;
        m_pc        = PC_INIT;
        m_instr     = 32'd0;
        m_delivered = 0;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] exp_count;
        exp_count = (m_delivered > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_delivered);
        checkValue({tag, ".imemREN"},     32'(bus.imemREN),     32'(m_waiting));
        checkValue({tag, ".imemaddr"},    bus.imemaddr,         m_pc);
        checkValue({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(m_holding));
        checkValue({tag, ".npc"},         bus.npc,              m_pc + 32'd4);
        checkValue({tag, ".instr"},       bus.instr,            m_instr);
        checkValue({tag, ".fetch_count"}, bus.fetch_count,      exp_count);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic applyStimulus(input string tag, input logic ih, input logic [31:0] il,
                                 input logic dr, input logic [1:0] src, input logic tk,
                                 input logic [15:0] imm, input logic [25:0] j,
                                 input logic [31:0] jr, input logic hl);
        bus.ihit         = ih;
        bus.iload        = il;
        bus.dec_ready    = dr;
        bus.PCSrc        = src;
        bus.branch_taken = tk;
        bus.imm16        = imm;
        bus.j_addr26     = j;
        bus.jr_addr      = jr;
        bus.halt         = hl;
        @(posedge clk);
        #1;
        if (m_waiting && ih) begin
            m_instr   = il;
            m_waiting = 1'b0;
            m_holding = 1'b1;
        end else if (m_holding && dr) begin
            m_pc = refTarget(m_pc, src, tk, imm, j, jr);
            m_delivered++;
            m_holding = 1'b0;
            m_waiting = !hl;
            m_stopped = hl;
        end
        checkOutput(tag);
    endtask

    task automatic fetchWord(input string tag);
        applyStimulus(tag, 1'b1, $urandom, 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
    endtask

    task automatic jumpReg(input string tag, input logic [31:0] target);
        fetchWord(tag);
        applyStimulus(tag, 1'b0, 32'd0, 1'b1, 2'd3, 1'b0, 16'd0, 26'd0, target, 1'b0);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.ihit = 1'b0; bus.iload = '0; bus.dec_ready = 1'b0; bus.PCSrc = 2'd0;
        bus.branch_taken = 1'b0; bus.imm16 = '0; bus.j_addr26 = '0; bus.jr_addr = '0;
        bus.halt = 1'b0;
        #2;
        doReset("reset");

        // Sequential fetch, zero-wait icache and always-ready decode.
        for (int i = 0; i < 8; i++) begin
            applyStimulus("seq", 1'b1, 32'h1000_0000 + 32'(i), 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
        end
        checkValue("seq.count4", bus.fetch_count, 32'd4);
        checkValue("seq.addr16", bus.imemaddr, 32'h0000_0010);

        // Taken and not-taken branch from 0x100.
        jumpReg("to100", 32'h0000_0100);
        fetchWord("br");
        applyStimulus("br_taken", 1'b0, 32'd0, 1'b1, 2'd1, 1'b1, 16'hFFFE, 26'd0, 32'd0, 1'b0);
        checkValue("br_taken.addr", bus.imemaddr, 32'h0000_00FC);
        jumpReg("to100b", 32'h0000_0100);
        fetchWord("brn");
        applyStimulus("br_not", 1'b0, 32'd0, 1'b1, 2'd1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 1'b0);
        checkValue("br_not.addr", bus.imemaddr, 32'h0000_0104);

        // Jump keeps the upper nibble of pc+4; jump-register clears the low bits.
        jumpReg("to4000", 32'h4000_0010);
        fetchWord("j");
        applyStimulus("jump", 1'b0, 32'd0, 1'b1, 2'd2, 1'b0, 16'd0, 26'h0000040, 32'd0, 1'b0);
        checkValue("jump.addr", bus.imemaddr, 32'h4000_0100);
        fetchWord("jr");
        applyStimulus("jr", 1'b0, 32'd0, 1'b1, 2'd3, 1'b0, 16'd0, 26'd0, 32'h0000_2003, 1'b0);
        checkValue("jr.addr", bus.imemaddr, 32'h0000_2000);

        // Icache miss stall, then decode stall.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("imiss", 1'b0, $urandom, 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
        end
        applyStimulus("ihit", 1'b1, 32'hCAFE_0001, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus("dstall", 1'b1, $urandom, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h0000_0800, 1'b0);
        end
        checkValue("dstall.instr", bus.instr, 32'hCAFE_0001);
        applyStimulus("dgo", 1'b0, 32'd0, 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);

        // Sequential wrap at the top of the address space.
        jumpReg("toTop", 32'hFFFF_FFFC);
        fetchWord("wrap");
        fetchWord("wrap");
        checkValue("wrap.addr", bus.imemaddr, 32'h0000_0000);

        // Reset while a word is held for decode at 0x200.
        jumpReg("to200", 32'h0000_0200);
        applyStimulus("hold200", 1'b1, 32'h1234_5678, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
        bus.ihit = 1'b1;
        #2;
        doReset("midReset");
        checkValue("midReset.addr", bus.imemaddr, PC_INIT);
        for (int i = 0; i < 4; i++) begin
            fetchWord("resume");
        end

        // Halt freezes the unit despite icache activity.
        fetchWord("preHalt");
        applyStimulus("halt", 1'b0, 32'd0, 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("halted", 1'($urandom_range(0, 1)), $urandom, 1'b1,
                          2'($urandom_range(0, 3)), 1'b1, 16'($urandom), 26'($urandom), $urandom, 1'b0);
        end
        checkValue("halted.ren", 32'(bus.imemREN), 32'd0);
        doReset("postHalt");

        // Random traffic; a halted unit is restarted after a few frozen cycles.
        begin
            int frozen = 0;
            for (int i = 0; i < 400; i++) begin
                applyStimulus("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                              26'($urandom), $urandom, 1'($urandom_range(0, 31) == 0));
                if (m_stopped) frozen++;
                if (frozen > 3) begin
                    frozen = 0;
                    doReset("randReset");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
